// File: rtl/oclib_pkg.sv
// Shared types and limits for the oclib reset sequencer.
package oclib_pkg;

    // Largest supported number of sequenced reset outputs.
    localparam int MaxResetSeqOutputs = 16;
    // Largest supported per-output acknowledge timeout, in cycles.
    localparam int MaxResetSeqTimeout = 65535;

    // Reset sequencer FSM states.
    typedef enum logic [2:0] {
        SEQ_ASSERT   = 3'd0,
        SEQ_HOLD     = 3'd1,
        SEQ_RELEASE  = 3'd2,
        SEQ_WAIT_ACK = 3'd3,
        SEQ_DONE     = 3'd4
    } reset_seq_state_e;

    // Bits needed for a counter that must reach max_val (always at least 1).
    function automatic int cnt_width(input int unsigned max_val);
        if (max_val < 32'd1) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'd1);
        end
    endfunction

endpackage

// File: rtl/oclib_reset_sequencer.sv
// oclib_reset_sequencer: asserts all downstream resets together, holds them,
// then releases them one at a time in index order, waiting for each domain's
// acknowledge plus a fixed gap before releasing the next one.
// Optional feature macro: OCLIB_RESET_SEQ_TIMEOUT_EN adds a sticky timeout
// output and stops waiting on an acknowledge after AckTimeout cycles.
module oclib_reset_sequencer
    import oclib_pkg::*;
#(
    parameter int Outputs    = 4,
    parameter int HoldCycles = 16,
    parameter int StepCycles = 4,
    parameter int AckTimeout = 255
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               request,
    input  logic [Outputs-1:0] ackIn,
    output logic [Outputs-1:0] resetOut,
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic               done
);

    // Clamp the ack budget into the supported range.
    localparam int AckLimit = (AckTimeout < 1) ? 1 :
                              ((AckTimeout > MaxResetSeqTimeout) ? MaxResetSeqTimeout : AckTimeout);

    // One shared counter times HOLD, the release gap and the ack wait.
    localparam int CntMaxHs = (HoldCycles > StepCycles) ? HoldCycles : StepCycles;
    localparam int CntMax   = (CntMaxHs > AckLimit) ? CntMaxHs : AckLimit;
    localparam int CntW     = cnt_width(CntMax);
    localparam int IdxW     = cnt_width(Outputs - 1);

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] StepLast = CntW'(StepCycles - 1);
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    localparam logic [CntW-1:0] AckLast  = CntW'(AckLimit - 1);
`endif
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(Outputs - 1);

    reset_seq_state_e   state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic               acked_q, acked_d;
    logic [Outputs-1:0] rst_out_q, rst_out_d;
    logic               done_q, done_d;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    logic               timeout_q, timeout_d;
`endif

    logic               ack_sel_s;
    logic [IdxW-1:0]    nxt_idx_s;
    logic               step_last_s;

    // Pick the acknowledge belonging to the output currently being released.
    always_comb begin
        ack_sel_s = 1'b0;
        for (int i = 0; i < Outputs; i++) begin
            if (idx_q == IdxW'(i)) begin
                ack_sel_s = ackIn[i];
            end else begin
                ack_sel_s = ack_sel_s;
            end
        end
    end

    assign nxt_idx_s = idx_q + IdxW'(1);
    // The cycle in which the ack is first seen counts as the first gap cycle.
    assign step_last_s = acked_q ? (cnt_q >= StepLast) : (StepLast == {CntW{1'b0}});

    // Next-state and next-output logic; request overrides every state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        acked_d   = acked_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        if (request) begin
            state_d   = SEQ_ASSERT;
            cnt_d     = {CntW{1'b0}};
            idx_d     = {IdxW{1'b0}};
            acked_d   = 1'b0;
            rst_out_d = {Outputs{1'b1}};
            done_d    = 1'b0;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end else begin
            case (state_q)
                SEQ_ASSERT: begin
                    state_d   = SEQ_HOLD;
                    cnt_d     = {CntW{1'b0}};
                    idx_d     = {IdxW{1'b0}};
                    rst_out_d = {Outputs{1'b1}};
                    done_d    = 1'b0;
                end
                SEQ_HOLD: begin
                    if (cnt_q >= HoldLast) begin
                        state_d      = SEQ_RELEASE;
                        cnt_d        = {CntW{1'b0}};
                        idx_d        = {IdxW{1'b0}};
                        rst_out_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                SEQ_RELEASE: begin
                    state_d = SEQ_WAIT_ACK;
                    cnt_d   = {CntW{1'b0}};
                    acked_d = 1'b0;
                end
                SEQ_WAIT_ACK: begin
                    if (acked_q || ack_sel_s) begin
                        acked_d = 1'b1;
                        if (step_last_s) begin
                            cnt_d   = {CntW{1'b0}};
                            acked_d = 1'b0;
                            if (idx_q >= LastIdx) begin
                                state_d = SEQ_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = SEQ_RELEASE;
                                idx_d   = nxt_idx_s;
                                for (int i = 0; i < Outputs; i++) begin
                                    if (nxt_idx_s == IdxW'(i)) begin
                                        rst_out_d[i] = 1'b0;
                                    end else begin
                                        rst_out_d[i] = rst_out_q[i];
                                    end
                                end
                            end
                        end else if (acked_q) begin
                            cnt_d = cnt_q + CntW'(1);
                        end else begin
                            cnt_d = CntW'(1);
                        end
                    end else begin
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
                        // Give up on this ack and run the gap as if it arrived.
                        if (cnt_q >= AckLast) begin
                            timeout_d = 1'b1;
                            acked_d   = 1'b1;
                            cnt_d     = {CntW{1'b0}};
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
`else
                        cnt_d = {CntW{1'b0}};
`endif
                    end
                end
                SEQ_DONE: begin
                    rst_out_d = {Outputs{1'b0}};
                    done_d    = 1'b1;
                end
                default: begin
                    state_d   = SEQ_ASSERT;
                    cnt_d     = {CntW{1'b0}};
                    idx_d     = {IdxW{1'b0}};
                    acked_d   = 1'b0;
                    rst_out_d = {Outputs{1'b1}};
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= SEQ_ASSERT;
            cnt_q     <= {CntW{1'b0}};
            idx_q     <= {IdxW{1'b0}};
            acked_q   <= 1'b0;
            rst_out_q <= {Outputs{1'b1}};
            done_q    <= 1'b0;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            acked_q   <= acked_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign resetOut = rst_out_q;
    assign done     = done_q;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    assign timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Directed bench for oclib_reset_sequencer. Cycle k is the k-th rising edge
// after the edge that put the FSM in ASSERT (last reset edge or request edge).
// With Outputs=4, HoldCycles=16, StepCycles=4 and acks high: bit i releases at
// k = 17 + 5*i and done rises at k = 37.
`timescale 1ns/1ps
module tb_oclib_reset_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req4;
    logic [3:0] ack4;
    logic [3:0] rst4;
    logic       done4;
    logic       req1;
    logic [0:0] ack1;
    logic [0:0] rst1;
    logic       done1;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    logic       to4;
    logic       to1;
    logic       reqt;
    logic [3:0] ackt;
    logic [3:0] rstt;
    logic       donet;
    logic       tot;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;

    oclib_reset_sequencer #(.Outputs(4), .HoldCycles(16), .StepCycles(4), .AckTimeout(255)) dut4 (
        .clock(clock), .resetn(resetn), .request(req4), .ackIn(ack4), .resetOut(rst4),
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        .timeout(to4),
`endif
        .done(done4));

    oclib_reset_sequencer #(.Outputs(1), .HoldCycles(1), .StepCycles(1), .AckTimeout(255)) dut1 (
        .clock(clock), .resetn(resetn), .request(req1), .ackIn(ack1), .resetOut(rst1),
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        .timeout(to1),
`endif
        .done(done1));

`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
    oclib_reset_sequencer #(.Outputs(4), .HoldCycles(16), .StepCycles(4), .AckTimeout(10)) dutt (
        .clock(clock), .resetn(resetn), .request(reqt), .ackIn(ackt), .resetOut(rstt),
        .timeout(tot), .done(donet));
`endif

    // Count one comparison and report it when it does not match.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (k=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) step();
    endtask

    // Expected resetOut for the 4-output, acks-high timeline.
    function automatic logic [3:0] exp_rst4(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (k < 17 + 5 * i);
        return v;
    endfunction

    task automatic pulse_req4();
        req4 = 1'b1;
        step();
        req4 = 1'b0;
        cyc = 0;
    endtask

    initial begin
        resetn = 1'b0;
        req4 = 1'b0; ack4 = 4'hF;
        req1 = 1'b0; ack1 = 1'b1;
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        reqt = 1'b0; ackt = 4'b1101;
`endif
        step();
        step();
        check_eq("rst4_reset", {28'd0, rst4}, 32'hF);
        check_eq("done4_reset", {31'd0, done4}, 32'd0);
        check_eq("rst1_reset", {31'd0, rst1}, 32'd1);
        check_eq("done1_reset", {31'd0, done1}, 32'd0);

        // Sequence after reset runs with no request.
        resetn = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            check_eq("rst4_boot", {28'd0, rst4}, {28'd0, exp_rst4(k)});
            check_eq("done4_boot", {31'd0, done4}, {31'd0, (k >= 37)});
            check_eq("rst1_boot", {31'd0, rst1}, {31'd0, (k < 2)});
            check_eq("done1_boot", {31'd0, done1}, {31'd0, (k >= 4)});
        end

        // Request gives all-ones one edge later, then restart mid-sequence.
        pulse_req4();
        check_eq("rst4_req_lat", {28'd0, rst4}, 32'hF);
        check_eq("done4_req_lat", {31'd0, done4}, 32'd0);
        adv_to(29);
        check_eq("rst4_idx2", {28'd0, rst4}, 32'h8);
        pulse_req4();
        check_eq("rst4_restart", {28'd0, rst4}, 32'hF);
        check_eq("done4_restart", {31'd0, done4}, 32'd0);
        adv_to(16);
        check_eq("rst4_rs_hold", {28'd0, rst4}, 32'hF);
        adv_to(17);
        check_eq("rst4_rs_bit0", {28'd0, rst4}, 32'hE);
        adv_to(36);
        check_eq("done4_rs_early", {31'd0, done4}, 32'd0);
        adv_to(37);
        check_eq("done4_rs", {31'd0, done4}, 32'd1);
        check_eq("rst4_rs_done", {28'd0, rst4}, 32'h0);

        // Request held high for 30 cycles keeps everything asserted.
        req4 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            check_eq("rst4_held", {28'd0, rst4}, 32'hF);
            check_eq("done4_held", {31'd0, done4}, 32'd0);
        end
        req4 = 1'b0;
        cyc = 0;
        adv_to(16);
        check_eq("rst4_held_hold", {28'd0, rst4}, 32'hF);
        adv_to(17);
        check_eq("rst4_held_bit0", {28'd0, rst4}, 32'hE);

        // ackIn[2] late by 50 cycles: bit 3 waits, earlier bits stay released.
        ack4 = 4'b1011;
        pulse_req4();
        adv_to(60);
        check_eq("rst4_ack_wait", {28'd0, rst4}, 32'h8);
        check_eq("done4_ack_wait", {31'd0, done4}, 32'd0);
        adv_to(77);
        ack4 = 4'hF;
        adv_to(80);
        check_eq("rst4_ack_gap", {28'd0, rst4}, 32'h8);
        adv_to(81);
        check_eq("rst4_ack_bit3", {28'd0, rst4}, 32'h0);
        adv_to(85);
        check_eq("done4_ack_early", {31'd0, done4}, 32'd0);
        adv_to(86);
        check_eq("done4_ack", {31'd0, done4}, 32'd1);
`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        check_eq("to4_none", {31'd0, to4}, 32'd0);
`endif

        // Minimal configuration: done five edges after the request is driven.
        req1 = 1'b1;
        step();
        req1 = 1'b0;
        cyc = 0;
        check_eq("rst1_req", {31'd0, rst1}, 32'd1);
        check_eq("done1_req", {31'd0, done1}, 32'd0);
        adv_to(1);
        check_eq("rst1_hold", {31'd0, rst1}, 32'd1);
        adv_to(2);
        check_eq("rst1_rel", {31'd0, rst1}, 32'd0);
        adv_to(3);
        check_eq("done1_early", {31'd0, done1}, 32'd0);
        adv_to(4);
        check_eq("done1_lat", {31'd0, done1}, 32'd1);

`ifdef OCLIB_RESET_SEQ_TIMEOUT_EN
        // ackIn[1] stuck low: timeout after 10 cycles in WAIT_ACK, then finish.
        reqt = 1'b1;
        step();
        reqt = 1'b0;
        cyc = 0;
        check_eq("tot_cleared", {31'd0, tot}, 32'd0);
        adv_to(32);
        check_eq("tot_early", {31'd0, tot}, 32'd0);
        adv_to(33);
        check_eq("tot_set", {31'd0, tot}, 32'd1);
        while (!donet && cyc < 200) step();
        check_eq("donet_after_to", {31'd0, donet}, 32'd1);
        check_eq("rstt_after_to", {28'd0, rstt}, 32'h0);
        check_eq("tot_sticky", {31'd0, tot}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
